// File: rtl/period_meter.sv
// Measures the number of idle cycles between consecutive pulseIn events,
// with saturation timeout, equal-period "stable" flag and synchronous re-arm.
module period_meter #(
  parameter int WIDTH = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulseIn,
  input  logic             clear,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             stable,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, MEASURE, TMO} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt;
  logic             armed;     // a capture has occurred since the last reference
  logic             capture, saturate, load, count;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic; clear overrides any event
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (pulseIn) state_nxt = MEASURE;
        MEASURE: if (!pulseIn && cnt == CNT_MAX) state_nxt = TMO;
        TMO:     if (pulseIn) state_nxt = MEASURE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // per-cycle action decode
  always_comb begin
    capture  = !clear && state == MEASURE && pulseIn;
    saturate = !clear && state == MEASURE && !pulseIn && cnt == CNT_MAX;
    load     = !clear && state != MEASURE && pulseIn;
    count    = !clear && state == MEASURE && !pulseIn && cnt != CNT_MAX;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      period  <= '0;
      valid   <= 1'b0;
      stable  <= 1'b0;
      timeout <= 1'b0;
      armed   <= 1'b0;
    end else begin
      valid <= capture;
      if (clear) begin
        cnt     <= '0;
        stable  <= 1'b0;
        timeout <= 1'b0;
        armed   <= 1'b0;
      end else if (capture) begin
        period <= cnt;
        cnt    <= '0;
        stable <= armed && (cnt == period);
        armed  <= 1'b1;
      end else if (saturate) begin
        timeout <= 1'b1;
        stable  <= 1'b0;
        armed   <= 1'b0;
      end else if (load) begin
        cnt     <= '0;
        timeout <= 1'b0;
      end else if (count) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Randomized + directed bench for period_meter against an event-time reference model.
module tb_period_meter;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset, pulseIn, clear;
  logic [W-1:0] period;
  logic         valid, stable, timeout;

  period_meter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .pulseIn(pulseIn), .clear(clear),
    .period(period), .valid(valid), .stable(stable), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: event times and list of captured periods
  int cyc;
  bit has_ref, tmo;
  int ref_cyc;
  int caps[$];
  int m_period;
  bit m_valid, m_stable;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    has_ref = 0; tmo = 0; caps.delete();
    m_period = 0; m_valid = 0; m_stable = 0;
  endtask

  task automatic model_edge(input bit p, input bit c);
    m_valid = 0;
    if (c) begin
      has_ref = 0; tmo = 0; caps.delete(); m_stable = 0;
    end else if (p) begin
      if (!has_ref || tmo) begin
        has_ref = 1; tmo = 0;
      end else begin
        m_period = cyc - ref_cyc - 1;
        m_valid  = 1;
        caps.push_back(m_period);
        m_stable = caps.size() >= 2 && caps[caps.size()-1] == caps[caps.size()-2];
      end
      ref_cyc = cyc;
    end else if (has_ref && !tmo && (cyc - ref_cyc - 1) == MAX) begin
      tmo = 1; m_stable = 0; caps.delete();
    end
    cyc++;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".period"},  int'(period),  m_period);
    chk({ctx, ".valid"},   int'(valid),   int'(m_valid));
    chk({ctx, ".stable"},  int'(stable),  int'(m_stable));
    chk({ctx, ".timeout"}, int'(timeout), int'(tmo));
  endtask

  task automatic step(input bit p, input bit c);
    @(negedge clk);
    pulseIn = p; clear = c;
    @(posedge clk);
    model_edge(p, c);
    #1 check_all("step");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic ev();
    step(1'b1, 1'b0);
  endtask

  // reset pulse placed between clock edges; outputs must drop before next edge
  task automatic async_reset();
    @(negedge clk);
    pulseIn = 1'b0; clear = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("areset");
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pulseIn = 1'b0; clear = 1'b0;
    cyc = 0; ref_cyc = 0;
    model_reset();
    #1 check_all("por");
    @(negedge clk); reset = 1'b0;

    // events every 5 cycles -> period 4, stable after 2nd capture
    ev(); idle(4); ev();
    chk("e5.stable1", int'(stable), 0);
    idle(4); ev();
    chk("e5.period", int'(period), 4);
    chk("e5.stable2", int'(stable), 1);
    idle(4); ev();

    // held-high pulse from IDLE
    step(1'b0, 1'b1);
    ev();
    chk("hold.ref_valid", int'(valid), 0);
    for (int i = 0; i < 5; i++) begin
      ev();
      chk("hold.valid", int'(valid), 1);
      chk("hold.period", int'(period), 0);
    end
    chk("hold.stable", int'(stable), 1);

    // intervals 5 then 8
    step(1'b0, 1'b1);
    ev(); idle(4); ev(); idle(7); ev();
    chk("i58.period", int'(period), 7);
    chk("i58.stable", int'(stable), 0);

    // saturation timeout and recovery
    step(1'b0, 1'b1);
    ev(); idle(20);
    chk("tmo.level", int'(timeout), 1);
    ev();
    chk("tmo.cleared", int'(timeout), 0);
    chk("tmo.novalid", int'(valid), 0);
    idle(2); ev();
    chk("tmo.period", int'(period), 2);
    chk("tmo.valid", int'(valid), 1);

    // clear with simultaneous event
    ev(); idle(3); step(1'b1, 1'b1);
    chk("clr.novalid", int'(valid), 0);
    ev();
    chk("clr.ref_only", int'(valid), 0);

    // async reset mid-measurement, then restart
    idle(3); async_reset();
    ev(); chk("rst.ref_only", int'(valid), 0);
    idle(3); ev(); chk("rst.period", int'(period), 3);

    // randomized bursts of periodic events, occasional clear/reset
    for (int b = 0; b < 300; b++) begin
      int g, k;
      g = $urandom_range(0, 18);
      k = $urandom_range(1, 5);
      for (int j = 0; j < k; j++) begin
        idle(g);
        step(1'b1, ($urandom_range(0, 40) == 0));
      end
      if ($urandom_range(0, 30) == 0) async_reset();
      if ($urandom_range(0, 20) == 0) idle($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter WIDTH, default 28, sets the bit width of the period counter and result.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pulseIn  input  1  synchronous to clk; every cycle sampled high is one event (a single-cycle enable strobe is one event).
REQ-005 clear  input  1  synchronous re-arm; discards any measurement in progress.
REQ-006 period  output  WIDTH  registered; number of non-event cycles between the last two events, i.e. the divider maxTime value.
REQ-007 valid  output  1  registered single-cycle strobe; period was updated this cycle.
REQ-008 stable  output  1  registered level; the last two captured periods were equal.
REQ-009 timeout  output  1  registered level; counter saturated with no event.

Function
REQ-010 FSM states: IDLE (no reference event yet), MEASURE (counting since the last event), TIMEOUT (counter saturated).
REQ-011 IDLE: an event loads cnt<=0 and moves to MEASURE; no valid strobe, period unchanged.
REQ-012 MEASURE, non-event cycle: cnt<=cnt+1.
REQ-013 MEASURE, event cycle: period<=cnt, valid<=1 for the next cycle only, cnt<=0, state stays MEASURE.
REQ-014 Latency: valid and the new period appear 1 cycle after the event cycle.
REQ-015 Back-to-back events (pulseIn held high) capture period=0 on every cycle, with valid high every cycle.
REQ-016 Events every N+1 cycles capture period=N.
REQ-017 stable<=1 on a capture whose cnt equals the currently held period and that is not the first capture since IDLE/TIMEOUT; any other capture clears stable<=0.
REQ-018 MEASURE, non-event cycle with cnt == 2^WIDTH-1: go to TIMEOUT, timeout<=1, stable<=0, cnt holds (no wrap).
REQ-019 TIMEOUT: period holds its last value; an event loads cnt<=0, clears timeout, and enters MEASURE with no valid strobe (the event acts as a new reference, like IDLE).
REQ-020 clear has priority over pulseIn: go to IDLE, cnt<=0, valid<=0, stable<=0, timeout<=0; period holds.
REQ-021 An event in the same cycle as clear is ignored.
REQ-022 All arithmetic is unsigned, WIDTH bits; cnt never wraps.

Reset
REQ-023 Asserting reset immediately forces state IDLE, cnt=0, period=0, valid=0, stable=0, timeout=0, regardless of clk.
REQ-024 Reset asserted mid-measurement discards the partial count.
REQ-025 The first event after reset release is treated as the reference event only.

Verification
REQ-026 Events every 5 cycles (divider maxTime=4), 4 events -> period=4 with valid at cycles E2+1, E3+1, E4+1; stable=0 after the first capture and 1 after the second and third.
REQ-027 pulseIn held high for 6 cycles from IDLE -> first cycle is the reference; period=0 with valid on each of the next 5 cycles; stable=1 from the second capture onward.
REQ-028 Event intervals 5, then 8 cycles -> period=4, then period=7; stable=0 after the second capture.
REQ-029 WIDTH=4, single event then idle for 20 cycles -> timeout=1 once cnt reaches 15 and stays; next event -> timeout=0, no valid; following event 3 cycles later -> period=2, valid.
REQ-030 clear asserted together with an event mid-MEASURE -> state IDLE, no valid; next event is the reference only.
REQ-031 reset asserted asynchronously between clk edges during MEASURE -> all outputs 0 before the next edge; measurement restarts from IDLE.
